// File: rtl/mem_access.sv
// mem_access: memory stage of a 64-bit pipelined datapath.
// Captures one execute-stage result, performs an optional load/store
// against a private DEPTH x 64-bit data memory over LATENCY cycles,
// then presents the write-back value, branch select and fault flag for
// one cycle with a done pulse.
//
// Optional feature: define MEM_MISALIGN_CHECK_EN to fault loads/stores
// whose byte address is not 8-byte aligned. When it is undefined the low
// three address bits are ignored.
module mem_access #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] alu_result,
  input  logic [63:0] read_data2,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem_to_reg,
  input  logic        branch,
  input  logic        uncond_branch,
  input  logic        zero,
  output logic        busy,
  output logic        done,
  output logic [63:0] write_data,
  output logic        pc_src,
  output logic        err
);

  localparam int          IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          ADDR_MSB = IDX_W + 2;
  localparam logic [63:0] LIMIT    = 64'(DEPTH) * 64'd8;
  localparam logic [3:0]  LAT      = 4'(LATENCY);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  // Operands captured when a new operation is accepted.
  logic [63:0] alu_q, store_q;
  logic        mr_q, mw_q, m2r_q, br_q, ub_q, zero_q;

  // Registered results, updated only when entering DONE so they hold otherwise.
  logic [63:0] write_data_q, write_data_d;
  logic        pc_src_q, pc_src_d;
  logic        err_q, err_d;

  logic [63:0] mem [DEPTH];

  // Operand view: raw inputs while idle (zero-latency path), captured copy otherwise.
  logic [63:0] op_alu;
  logic        op_mr, op_mw, op_m2r, op_br, op_ub, op_zero;
  logic [IDX_W-1:0] idx;
  logic        out_of_range, misaligned, bad_addr, is_mem;
  logic [63:0] load_word;
  logic        capture, last_access, finish, store_en;

  // Select which copy of the operation fields feeds the result logic.
  always_comb begin
    if (state_q == IDLE) begin
      op_alu  = alu_result;
      op_mr   = mem_read;
      op_mw   = mem_write;
      op_m2r  = mem_to_reg;
      op_br   = branch;
      op_ub   = uncond_branch;
      op_zero = zero;
    end else begin
      op_alu  = alu_q;
      op_mr   = mr_q;
      op_mw   = mw_q;
      op_m2r  = m2r_q;
      op_br   = br_q;
      op_ub   = ub_q;
      op_zero = zero_q;
    end
  end

  assign idx          = op_alu[ADDR_MSB:3];
  assign out_of_range = (op_alu >= LIMIT);
`ifdef MEM_MISALIGN_CHECK_EN
  assign misaligned   = (op_alu[2:0] != 3'd0);
`else
  assign misaligned   = 1'b0;
`endif
  assign bad_addr     = out_of_range | misaligned;
  assign is_mem       = op_mr | op_mw;
  assign load_word    = (op_mr && !bad_addr) ? mem[idx] : 64'd0;

  // FSM next state, counter, control strobes and result next values.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d      = state_q;
    cnt_d        = cnt_q;
    capture      = 1'b0;
    last_access  = 1'b0;
    busy         = (state_q != IDLE);
    done         = (state_q == DONE);
    write_data_d = write_data_q;
    pc_src_d     = pc_src_q;
    err_d        = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          capture = 1'b1;
          if (mem_read | mem_write) begin
            state_d = ACCESS;
            cnt_d   = LAT;
          end else begin
            state_d = DONE;
          end
        end
      end
      ACCESS: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d     = DONE;
          last_access = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    finish = (capture && !is_mem) || last_access;
    if (finish) begin
      write_data_d = op_m2r ? load_word : op_alu;
      pc_src_d     = op_ub | (op_br & op_zero);
      err_d        = is_mem & (bad_addr | (op_mr & op_mw));
    end
  end

  // A store commits only on its final access cycle, never on a reset cycle.
  assign store_en = last_access && op_mw && !op_mr && !bad_addr && !reset;

  // State, counter and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      write_data_q <= 64'd0;
      pc_src_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_data_q <= write_data_d;
      pc_src_q     <= pc_src_d;
      err_q        <= err_d;
    end
  end

  // Operand capture; only loads while idle so busy-time starts cannot disturb it.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_q   <= 64'd0;
      store_q <= 64'd0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      m2r_q   <= 1'b0;
      br_q    <= 1'b0;
      ub_q    <= 1'b0;
      zero_q  <= 1'b0;
    end else if (capture) begin
      alu_q   <= alu_result;
      store_q <= read_data2;
      mr_q    <= mem_read;
      mw_q    <= mem_write;
      m2r_q   <= mem_to_reg;
      br_q    <= branch;
      ub_q    <= uncond_branch;
      zero_q  <= zero;
    end
  end

  // Data memory write port.
  always_ff @(posedge clk) begin
    // NOTE: the memory array has no reset; its contents must survive a reset.
    if (store_en) begin
      mem[idx] <= store_q;
    end
  end

  assign write_data = write_data_q;
  assign pc_src     = pc_src_q;
  assign err        = err_q;

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: randomized and directed checks of mem_access against a
// transaction-level reference model (array memory, per-operation rules).
module tb_mem_access;

  localparam int DEPTH   = 64;
  localparam int LATENCY = 2;
`ifdef MEM_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start;
  logic [63:0] alu_result, read_data2;
  logic        mem_read, mem_write, mem_to_reg, branch, uncond_branch, zero;
  logic        busy, done;
  logic [63:0] write_data;
  logic        pc_src, err;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] model_mem [DEPTH];

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    logic        mr, mw, m2r, br, ub, z;
  } op_t;

  mem_access #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .reset(reset), .start(start),
    .alu_result(alu_result), .read_data2(read_data2),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .branch(branch), .uncond_branch(uncond_branch), .zero(zero),
    .busy(busy), .done(done), .write_data(write_data),
    .pc_src(pc_src), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic op_t mk(input logic [63:0] addr, input logic [63:0] data,
                             input logic mr, input logic mw, input logic m2r,
                             input logic br, input logic ub, input logic z);
    op_t o;
    o.addr = addr; o.data = data; o.mr = mr; o.mw = mw;
    o.m2r = m2r; o.br = br; o.ub = ub; o.z = z;
    return o;
  endfunction

  task automatic drive_idle();
    start = 1'b0; alu_result = '0; read_data2 = '0;
    mem_read = 0; mem_write = 0; mem_to_reg = 0;
    branch = 0; uncond_branch = 0; zero = 0;
  endtask

  task automatic drive_op(input op_t o);
    alu_result = o.addr; read_data2 = o.data;
    mem_read = o.mr; mem_write = o.mw; mem_to_reg = o.m2r;
    branch = o.br; uncond_branch = o.ub; zero = o.z;
  endtask

  // Reference model: one whole operation computed from the architectural rules.
  task automatic model_op(input op_t o, output logic [63:0] wd, output logic pc,
                          output logic e, output int lat);
    bit is_mem, bad;
    logic [63:0] loaded;
    int i;
    is_mem = o.mr || o.mw;
    bad    = (o.addr >= 64'(DEPTH * 8)) || (MIS_EN && (o.addr % 8 != 0));
    i      = int'((o.addr / 8) % DEPTH);
    loaded = (o.mr && !bad) ? model_mem[i] : 64'd0;
    if (o.mw && !o.mr && !bad) model_mem[i] = o.data;
    wd  = o.m2r ? loaded : o.addr;
    pc  = o.ub || (o.br && o.z);
    e   = is_mem && (bad || (o.mr && o.mw));
    lat = is_mem ? 1 + LATENCY : 1;
  endtask

  // Issue one operation; optionally hammer start with a different op while busy.
  task automatic run_op(input op_t o, input bit disturb);
    logic [63:0] exp_wd;
    logic        exp_pc, exp_err;
    int          exp_lat, lat;
    model_op(o, exp_wd, exp_pc, exp_err, exp_lat);
    @(negedge clk);
    drive_op(o);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    lat = 1;
    start = 1'b0;
    if (disturb && !done) begin
      start = 1'b1;
      alu_result = ~o.addr; read_data2 = {$urandom, $urandom};
      mem_read = 1'($urandom); mem_write = 1'($urandom); mem_to_reg = ~o.m2r;
      branch = ~o.br; uncond_branch = 1'($urandom); zero = ~o.z;
    end
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check("done_seen", 64'(done), 64'd1);
    check("latency", 64'(lat), 64'(exp_lat));
    check("busy_done", 64'(busy), 64'd1);
    check("write_data", write_data, exp_wd);
    check("pc_src", 64'(pc_src), 64'(exp_pc));
    check("err", 64'(err), 64'(exp_err));
    drive_idle();
    @(negedge clk);
    check("done_pulse", 64'(done), 64'd0);
    check("busy_idle", 64'(busy), 64'd0);
    check("wd_hold", write_data, exp_wd);
    check("err_hold", 64'(err), 64'(exp_err));
  endtask

  initial begin
    op_t o;
    bit  saw_done;
    int  kind;

    drive_idle();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_wd", write_data, 64'd0);
    check("rst_pc", 64'(pc_src), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    reset = 1'b0;

    // Fill memory with known values so every later load is predictable.
    for (int i = 0; i < DEPTH; i++)
      run_op(mk(64'(i * 8), {$urandom, $urandom}, 0, 1, 0, 0, 0, 0), 1'b0);

    // Store then load back at 16.
    run_op(mk(64'd16, 64'd1234, 0, 1, 0, 0, 0, 0), 1'b0);
    run_op(mk(64'd16, 64'd0, 1, 0, 1, 0, 0, 0), 1'b0);
    check("load_1234", write_data, 64'd1234);

    // Non-memory pass-through with branch decisions.
    run_op(mk(64'd30, 64'd0, 0, 0, 0, 1, 0, 1), 1'b0);
    run_op(mk(64'd30, 64'd0, 0, 0, 0, 1, 0, 0), 1'b0);
    run_op(mk(64'd30, 64'd0, 0, 0, 0, 0, 1, 0), 1'b0);

    // Out-of-range load and store; index 0 (alias of 512) must be untouched.
    run_op(mk(64'd512, 64'd0, 1, 0, 1, 0, 0, 0), 1'b0);
    run_op(mk(64'd512, 64'hDEAD, 0, 1, 0, 0, 0, 0), 1'b0);
    run_op(mk(64'd0, 64'd0, 1, 0, 1, 0, 0, 0), 1'b0);

    // Reset during the first access cycle of a store of 20 to address 8.
    @(negedge clk);
    drive_op(mk(64'd8, 64'd20, 0, 1, 0, 0, 0, 0));
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive_idle();
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_wd", write_data, 64'd0);
    saw_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", 64'(saw_done), 64'd0);
    run_op(mk(64'd8, 64'd0, 1, 0, 1, 0, 0, 0), 1'b0);

    // Start while busy must not disturb the operation in flight.
    run_op(mk(64'd40, 64'hCAFE_F00D, 0, 1, 0, 0, 0, 0), 1'b1);
    run_op(mk(64'd40, 64'd0, 1, 0, 1, 0, 0, 0), 1'b1);
    run_op(mk(64'd77, 64'd0, 0, 0, 0, 1, 0, 1), 1'b1);

    // Misaligned accesses at 12, and a read+write conflict at 24.
    run_op(mk(64'd12, 64'd0, 1, 0, 1, 0, 0, 0), 1'b0);
    run_op(mk(64'd12, 64'h5555, 0, 1, 0, 0, 0, 0), 1'b0);
    run_op(mk(64'd8, 64'd0, 1, 0, 1, 0, 0, 0), 1'b0);
    run_op(mk(64'd24, 64'h9999, 1, 1, 1, 0, 0, 0), 1'b0);
    run_op(mk(64'd24, 64'd0, 1, 0, 1, 0, 0, 0), 1'b0);

    // Randomized mix of all operation kinds.
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 9);
      o = mk(64'($urandom_range(0, DEPTH - 1) * 8), {$urandom, $urandom},
             1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom));
      if (kind == 0) o.addr = 64'(DEPTH * 8 + $urandom_range(0, 4000));
      else if (kind == 1) o.addr = 64'($urandom_range(0, DEPTH * 8 - 1));
      else if (kind == 2) o.addr = {$urandom, $urandom};
      if (kind >= 7) o.mr = ~o.mw;
      run_op(o, 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
